// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: segment table and
// active-low polarity constants for anodes and cathodes.
package sseg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic       AN_ON   = 1'b0;
    localparam logic       AN_OFF  = 1'b1;
    localparam logic       CA_ON   = 1'b0;
    localparam logic       CA_OFF  = 1'b1;

    // Active-low g..a patterns for hex digits 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib, input logic dp);
        return {dp ? CA_ON : CA_OFF, HEX_SEG[nib]};
    endfunction

endpackage

// File: rtl/sseg_tick_gen.sv
// Prescaler: TICK is high for one clock out of every SUB clocks.
module sseg_tick_gen #(
    parameter int unsigned SUB = 1
) (
    input  logic CLK,
    input  logic RST_N,
    output logic TICK
);

    localparam int unsigned     CW   = (SUB > 1) ? $clog2(SUB) : 1;
    localparam logic [CW-1:0]   LAST = CW'(SUB - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        TICK  = (cnt_q == LAST);
        cnt_d = TICK ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment driver with per-slot PWM dimming, guard phase,
// frame-synchronous data update, blanking and leading-zero suppression.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned SCAN_HZ    = 1000,
    parameter int unsigned DIM_BITS   = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [4*NUM_DIGITS-1:0] DATA_IN,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    input  logic [NUM_DIGITS-1:0]   BLANK_IN,
    input  logic                    LOAD,
    input  logic                    LZ_SUPPRESS,
    input  logic [DIM_BITS-1:0]     BRIGHT,
    output logic [7:0]              SSEG_CA,
    output logic [NUM_DIGITS-1:0]   SSEG_AN,
    output logic                    FRAME_DONE
);

    localparam int unsigned PHASES = 1 << DIM_BITS;
    localparam int unsigned SUB    = CLK_HZ / (SCAN_HZ * PHASES);
    localparam int unsigned DW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (SUB < 1) begin : g_bad_sub
        $error("sseg_scan_driver: CLK_HZ too low for SCAN_HZ and DIM_BITS");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("sseg_scan_driver: NUM_DIGITS must be 1..8");
    end

    logic                    tick;
    logic                    phase_wrap, frame_wrap;
    logic [DIM_BITS-1:0]     phase_q, phase_d, bright_q, bright_d;
    logic [DW-1:0]           digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              ca_q, ca_d;
    logic                    frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    lz_live;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_blank;

    sseg_tick_gen #(
        .SUB(SUB)
    ) u_tick_gen (
        .CLK  (CLK),
        .RST_N(RST_N),
        .TICK (tick)
    );

    // Scan position, brightness latch and shadow-to-active transfer
    always_comb begin
        phase_d      = phase_q;
        digit_d      = digit_q;
        bright_d     = bright_q;
        frame_done_d = 1'b0;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_vld_d   = pend_vld_q;
        phase_wrap   = &phase_q;
        frame_wrap   = phase_wrap && (digit_q == DW'(NUM_DIGITS - 1));

        if (tick) begin
            phase_d = phase_q + 1'b1;
            if (phase_q == '0) bright_d = BRIGHT;
            if (phase_wrap) digit_d = frame_wrap ? '0 : digit_q + 1'b1;
            frame_done_d = frame_wrap;
        end

        if (tick && frame_wrap && LOAD) begin
            act_data_d  = DATA_IN;
            act_dp_d    = DP_IN;
            act_blank_d = BLANK_IN;
            pend_vld_d  = 1'b0;
        end else if (tick && frame_wrap && pend_vld_q) begin
            act_data_d  = pend_data_q;
            act_dp_d    = pend_dp_q;
            act_blank_d = pend_blank_q;
            pend_vld_d  = 1'b0;
        end else if (LOAD) begin
            pend_data_d  = DATA_IN;
            pend_dp_d    = DP_IN;
            pend_blank_d = BLANK_IN;
            pend_vld_d   = 1'b1;
        end
    end

    // Registered anode/cathode drive; cathodes only change at the guard phase
    always_comb begin
        an_d      = an_q;
        ca_d      = ca_q;
        lz_mask   = '0;
        lz_live   = LZ_SUPPRESS;
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;

        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (lz_live && act_data_d[4*i +: 4] == 4'h0 && !act_dp_d[i]) begin
                lz_mask[i] = 1'b1;
            end else begin
                lz_live = 1'b0;
            end
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_d == DW'(i)) begin
                cur_nib   = act_data_d[4*i +: 4];
                cur_dp    = act_dp_d[i];
                cur_blank = act_blank_d[i] | lz_mask[i];
            end
        end

        if (tick) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (digit_d == DW'(i) && phase_d != '0 && phase_d <= bright_d)
                          ? AN_ON : AN_OFF;
            end
            if (phase_d == '0) ca_d = cur_blank ? SEG_OFF : hex_to_seg(cur_nib, cur_dp);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase_q      <= '0;
            digit_q      <= '0;
            bright_q     <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_vld_q   <= 1'b0;
            an_q         <= '1;
            ca_q         <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            digit_q      <= digit_d;
            bright_q     <= bright_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_vld_q   <= pend_vld_d;
            an_q         <= an_d;
            ca_q         <= ca_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign SSEG_AN    = an_q;
    assign SSEG_CA    = ca_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed self-checking bench for sseg_scan_driver (4 digits, one clock per phase,
// 16-clock slots, 64-clock frames).
module tb_sseg_scan_driver;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] DATA_IN;
    logic [3:0]  DP_IN, BLANK_IN;
    logic        LOAD, LZ_SUPPRESS;
    logic [3:0]  BRIGHT;
    logic [7:0]  SSEG_CA;
    logic [3:0]  SSEG_AN;
    logic        FRAME_DONE;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] obs_an [64];
    logic [7:0] obs_ca [64];
    logic       obs_fd [64];

    sseg_scan_driver #(
        .NUM_DIGITS(4),
        .CLK_HZ    (1600),
        .SCAN_HZ   (100),
        .DIM_BITS  (4)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .DATA_IN    (DATA_IN),
        .DP_IN      (DP_IN),
        .BLANK_IN   (BLANK_IN),
        .LOAD       (LOAD),
        .LZ_SUPPRESS(LZ_SUPPRESS),
        .BRIGHT     (BRIGHT),
        .SSEG_CA    (SSEG_CA),
        .SSEG_AN    (SSEG_AN),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    // Expected anodes at frame cycle c (digit c/16, phase c%16)
    function automatic logic [3:0] exp_an_f(input int c, input int br);
        logic [3:0] a;
        int ph, dg;
        ph = c % 16;
        dg = c / 16;
        a  = 4'hF;
        if (ph != 0 && ph <= br) a[dg] = 1'b0;
        return a;
    endfunction

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        @(negedge CLK);
        DATA_IN  = d;
        DP_IN    = dp;
        BLANK_IN = bl;
        LOAD     = 1'b1;
        @(negedge CLK);
        LOAD     = 1'b0;
    endtask

    task automatic wait_frame();
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge CLK);
            if (FRAME_DONE === 1'b1) found = 1;
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_wait: FRAME_DONE not seen within 200 clocks (required within 64)");
        end
    endtask

    // Records one 64-clock frame starting at the current negedge; optionally strobes LOAD
    task automatic capture_frame(input int load_at, input logic [15:0] ld);
        for (int c = 0; c < 64; c++) begin
            obs_an[c] = SSEG_AN;
            obs_ca[c] = SSEG_CA;
            obs_fd[c] = FRAME_DONE;
            if (c == load_at) begin
                DATA_IN = ld;
                LOAD    = 1'b1;
            end else begin
                LOAD    = 1'b0;
            end
            @(negedge CLK);
        end
        LOAD = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if (SSEG_AN !== 4'hF) begin
            n_bad++;
            $display("FAIL reset_an: got %h required F", SSEG_AN);
        end
        n_cmp++;
        if (SSEG_CA !== 8'hFF) begin
            n_bad++;
            $display("FAIL reset_ca: got %h required FF", SSEG_CA);
        end
        n_cmp++;
        if (FRAME_DONE !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_fd: got %b required 0", FRAME_DONE);
        end
        RST_N = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge CLK);
            #1;
            n++;
            if (FRAME_DONE === 1'b1) break;
        end
        n_cmp++;
        if (n != 64) begin
            n_bad++;
            $display("FAIL reset_first_frame: got %0d clocks required 64", n);
        end
    endtask

    task automatic test_hex_bright15();
        logic [12:0] exp_v;
        logic [31:0] ca_exp = {8'hF9, 8'hA4, 8'h88, 8'h8E};
        BRIGHT = 4'd15;
        do_load(16'h12AF, 4'h0, 4'h0);
        wait_frame();
        capture_frame(-1, 16'h0);
        for (int c = 0; c < 64; c++) begin
            n_cmp++;
            exp_v = {c == 0, exp_an_f(c, 15), ca_exp[8*(c/16) +: 8]};
            if ({obs_fd[c], obs_an[c], obs_ca[c]} !== exp_v) begin
                n_bad++;
                $display("FAIL hex_bright15 c=%0d: got %h required %h", c,
                         {obs_fd[c], obs_an[c], obs_ca[c]}, exp_v);
            end
        end
    endtask

    task automatic test_bright();
        logic [12:0] exp_v;
        logic [31:0] ca_exp = {8'hF9, 8'hA4, 8'h88, 8'h8E};
        BRIGHT = 4'd3;
        wait_frame();
        capture_frame(-1, 16'h0);
        for (int c = 0; c < 64; c++) begin
            n_cmp++;
            exp_v = {c == 0, exp_an_f(c, 3), ca_exp[8*(c/16) +: 8]};
            if ({obs_fd[c], obs_an[c], obs_ca[c]} !== exp_v) begin
                n_bad++;
                $display("FAIL bright3 c=%0d: got %h required %h", c,
                         {obs_fd[c], obs_an[c], obs_ca[c]}, exp_v);
            end
        end
        BRIGHT = 4'd0;
        wait_frame();
        capture_frame(-1, 16'h0);
        for (int c = 0; c < 64; c++) begin
            n_cmp++;
            exp_v = {c == 0, 4'hF, ca_exp[8*(c/16) +: 8]};
            if ({obs_fd[c], obs_an[c], obs_ca[c]} !== exp_v) begin
                n_bad++;
                $display("FAIL bright0 c=%0d: got %h required %h", c,
                         {obs_fd[c], obs_an[c], obs_ca[c]}, exp_v);
            end
        end
    endtask

    task automatic test_lz();
        logic [12:0] exp_v;
        logic [31:0] ca_exp [3] = '{{8'hFF, 8'hFF, 8'h99, 8'hC0},
                                    {8'h40, 8'hC0, 8'h99, 8'hC0},
                                    {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        logic [15:0] data [3] = '{16'h0040, 16'h0040, 16'h0000};
        logic [3:0]  dps  [3] = '{4'b0000, 4'b1000, 4'b0000};
        BRIGHT      = 4'd15;
        LZ_SUPPRESS = 1'b1;
        for (int t = 0; t < 3; t++) begin
            do_load(data[t], dps[t], 4'h0);
            wait_frame();
            capture_frame(-1, 16'h0);
            for (int c = 0; c < 64; c++) begin
                n_cmp++;
                exp_v = {c == 0, exp_an_f(c, 15), ca_exp[t][8*(c/16) +: 8]};
                if ({obs_fd[c], obs_an[c], obs_ca[c]} !== exp_v) begin
                    n_bad++;
                    $display("FAIL lz_suppress case=%0d c=%0d: got %h required %h", t, c,
                             {obs_fd[c], obs_an[c], obs_ca[c]}, exp_v);
                end
            end
        end
        LZ_SUPPRESS = 1'b0;
    endtask

    task automatic test_blank();
        logic [12:0] exp_v;
        logic [31:0] ca_exp = {8'hF9, 8'hA4, 8'hFF, 8'h8E};
        do_load(16'h12AF, 4'h0, 4'b0010);
        wait_frame();
        capture_frame(-1, 16'h0);
        for (int c = 0; c < 64; c++) begin
            n_cmp++;
            exp_v = {c == 0, exp_an_f(c, 15), ca_exp[8*(c/16) +: 8]};
            if ({obs_fd[c], obs_an[c], obs_ca[c]} !== exp_v) begin
                n_bad++;
                $display("FAIL blank c=%0d: got %h required %h", c,
                         {obs_fd[c], obs_an[c], obs_ca[c]}, exp_v);
            end
        end
    endtask

    task automatic test_load_timing();
        logic [12:0] exp_v;
        logic [31:0] ca_exp [3] = '{{8'hF9, 8'hA4, 8'h88, 8'h8E},
                                    {8'hF9, 8'hF9, 8'hF9, 8'hF9},
                                    {8'h92, 8'h82, 8'hF8, 8'h80}};
        int          ld_at  [3] = '{37, 63, -1};
        logic [15:0] ld_dat [3] = '{16'h1111, 16'h5678, 16'h0000};
        do_load(16'h12AF, 4'h0, 4'h0);
        wait_frame();
        // Three back-to-back frames: mid-frame LOAD, LOAD at the wrap cycle, result
        for (int f = 0; f < 3; f++) begin
            capture_frame(ld_at[f], ld_dat[f]);
            for (int c = 0; c < 64; c++) begin
                n_cmp++;
                exp_v = {c == 0, exp_an_f(c, 15), ca_exp[f][8*(c/16) +: 8]};
                if ({obs_fd[c], obs_an[c], obs_ca[c]} !== exp_v) begin
                    n_bad++;
                    $display("FAIL load_timing frame=%0d c=%0d: got %h required %h", f, c,
                             {obs_fd[c], obs_an[c], obs_ca[c]}, exp_v);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp_v;
        do_load(16'hAAAA, 4'h0, 4'h0);
        do_load(16'h5555, 4'h0, 4'h0);
        wait_frame();
        capture_frame(-1, 16'h0);
        for (int c = 0; c < 64; c++) begin
            n_cmp++;
            exp_v = {c == 0, exp_an_f(c, 15), 8'h92};
            if ({obs_fd[c], obs_an[c], obs_ca[c]} !== exp_v) begin
                n_bad++;
                $display("FAIL back_to_back c=%0d: got %h required %h", c,
                         {obs_fd[c], obs_an[c], obs_ca[c]}, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] exp_v;
        int n;
        do_load(16'h9999, 4'h0, 4'h0);
        repeat (19) @(negedge CLK);
        n_cmp++;
        if (SSEG_AN !== 4'b1101) begin
            n_bad++;
            $display("FAIL pre_reset_an: got %b required 1101", SSEG_AN);
        end
        #2 RST_N = 1'b0;
        #1;
        n_cmp++;
        if ({FRAME_DONE, SSEG_AN, SSEG_CA} !== {1'b0, 4'hF, 8'hFF}) begin
            n_bad++;
            $display("FAIL async_reset: got %h required 0FFF", {FRAME_DONE, SSEG_AN, SSEG_CA});
        end
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge CLK);
            #1;
            n++;
            if (FRAME_DONE === 1'b1) break;
        end
        n_cmp++;
        if (n != 64) begin
            n_bad++;
            $display("FAIL reset_mid_first_frame: got %0d clocks required 64", n);
        end
        @(negedge CLK);
        capture_frame(-1, 16'h0);
        for (int c = 0; c < 64; c++) begin
            n_cmp++;
            exp_v = {c == 0, exp_an_f(c, 15), 8'hC0};
            if ({obs_fd[c], obs_an[c], obs_ca[c]} !== exp_v) begin
                n_bad++;
                $display("FAIL reset_mid_cleared c=%0d: got %h required %h", c,
                         {obs_fd[c], obs_an[c], obs_ca[c]}, exp_v);
            end
        end
    endtask

    initial begin
        RST_N       = 1'b0;
        LOAD        = 1'b0;
        DATA_IN     = 16'h0;
        DP_IN       = 4'h0;
        BLANK_IN    = 4'h0;
        LZ_SUPPRESS = 1'b0;
        BRIGHT      = 4'd15;
        test_reset();
        test_hex_bright15();
        test_bright();
        test_lz();
        test_blank();
        test_load_timing();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
